pipe_stall_ctrl: RTL



---
 rtl/pipe_stall_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: central stall/flush controller for the 5-stage pipeline.
// Merges load-use hazards, mult/div (HI/LO) sequencing, data-memory wait
// freezes and EX-stage redirects into one set of per-stage write enables,
// flushes and a mult/div start strobe.
module pipe_stall_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_MemRead,
    input  logic [4:0]  ex_rt,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_md_op,
    input  logic        id_md_div,
    input  logic        id_hilo_use,
    input  logic        mem_wait,
    input  logic        ex_redirect,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_write,
    output logic        idex_flush,
    output logic        exmem_write,
    output logic        md_start,
    output logic        md_busy,
    output logic [15:0] stall_cnt
);

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } mdState_t;

    mdState_t         r_mdState;
    mdState_t         w_mdStateNext;
    logic [CNT_W-1:0] r_mdCnt;
    logic [CNT_W-1:0] w_mdCntNext;
    logic [15:0]      r_stallCnt;

    logic w_loadUse;
    logic w_mdHazard;
    logic w_hazard;
    logic w_stallInc;

    // Hazard detection; register 0 never creates a load-use dependency, and
    // md_busy is masked while reset is held so a mid-divide reset reads idle.
    always_comb begin
        md_busy    = (r_mdState == MD_BUSY) && !reset;
        w_loadUse  = ex_MemRead && (ex_rt != 5'd0) &&
                     ((id_rs == ex_rt) || (id_rt == ex_rt));
        w_mdHazard = md_busy && (id_md_op || id_hilo_use);
        w_hazard   = w_loadUse || w_mdHazard;
    end

    // Priority resolution: reset > mem_wait > ex_redirect > hazard > normal.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_write  = 1'b1;
        idex_flush  = 1'b0;
        exmem_write = 1'b1;
        md_start    = 1'b0;
        w_stallInc  = 1'b0;
        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end else if (mem_wait) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
        end else if (ex_redirect) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end else if (w_hazard) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_flush  = 1'b1;
            w_stallInc  = 1'b1;
        end else begin
            md_start    = id_md_op;
        end
    end

    // Mult/div sequencer next state: load the latency on start, count down to 0.
    always_comb begin
        w_mdStateNext = r_mdState;
        w_mdCntNext   = r_mdCnt;
        case (r_mdState)
            MD_IDLE: begin
                if (md_start) begin
                    w_mdStateNext = MD_BUSY;
                    w_mdCntNext   = id_md_div ? CNT_W'(DIV_CYCLES - 1)
                                              : CNT_W'(MUL_CYCLES - 1);
                end
            end
            MD_BUSY: begin
                if (r_mdCnt == '0) begin
                    w_mdStateNext = MD_IDLE;
                end else begin
                    w_mdCntNext = r_mdCnt - 1'b1;
                end
            end
            default: begin
                w_mdStateNext = MD_IDLE;
                w_mdCntNext   = '0;
            end
        endcase
    end

    // Sequencer state register; keeps counting through memory freezes.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mdState <= MD_IDLE;
            r_mdCnt   <= '0;
        end else begin
            r_mdState <= w_mdStateNext;
            r_mdCnt   <= w_mdCntNext;
        end
    end

    // Saturating count of cycles lost to genuine hazard stalls.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stallCnt <= 16'd0;
        end else if (w_stallInc && (r_stallCnt != 16'hFFFF)) begin
            r_stallCnt <= r_stallCnt + 16'd1;
        end
    end

    assign stall_cnt = r_stallCnt;

endmodule
